spi_slave_control: RTL and testbench
====================================

SPI_SLAVE_CONTROL -- requirements
Module: spi_slave_control

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, the number of synchronizer flops on SCK, CS and MOSI (minimum 2).
REQ-002 SHALL have one clock and an asynchronous, active-low reset, named CLK and CLR.
REQ-003 CLK  input  1  system clock; all state is on the rising edge.
REQ-004 CLR  input  1  asynchronous active-low reset.
REQ-005 SCK  input  1  SPI serial clock from the master, asynchronous to CLK.
REQ-006 CS  input  1  chip select from the master, active-low, asynchronous.
REQ-007 MOSI  input  1  serial data from the master.
REQ-008 MISO  output  1  serial data to the master.
REQ-009 MISO_OE  output  1  MISO drive enable; high only while selected and TE=1.
REQ-010 TX_DATA  input  8  byte to be sent on MISO.
REQ-011 WRITE  input  1  one-CLK pulse that loads TX_DATA into the TX buffer.
REQ-012 READ  input  1  one-CLK pulse that pops the RX buffer.
REQ-013 RX_DATA  output  8  last received byte.
REQ-014 CONTROL  input  8  configuration: [2] TE (transmit enable), [6] RE (receive enable), [3] CLR_ERR (write-1 pulse that clears sticky flags); other bits reserved.
REQ-015 STATUS  output  8  status: [0] TX_FULL, [1] RX_FULL, [2] RX_OVERRUN, [3] TX_UNDERRUN, [4] FRAME_ERR, [7] SELECTED; other bits 0.

Function
REQ-016 SHALL implement SPI mode 0 only: MSB first; MOSI sampled on the synchronized SCK rising edge; MISO updated on the synchronized SCK falling edge.
REQ-017 SHALL detect SCK and CS edges from the synchronized signals; SCK high and low phases of at least SYNC_STAGES+1 CLK periods each are required.
REQ-018 SHALL use an FSM with states IDLE, LOAD and SHIFT.
REQ-019 IDLE -> LOAD on synchronized CS falling edge. LOAD -> SHIFT after exactly one CLK. SHIFT -> LOAD after the 8th sampled bit. Any state -> IDLE on synchronized CS high.
REQ-020 In LOAD: if TX_FULL, the shift register SHALL take the TX buffer contents and TX_FULL SHALL clear; otherwise it SHALL take 8'h00 and TX_UNDERRUN SHALL set (only when TE=1).
REQ-021 MISO SHALL present shift register bit 7 from LOAD onward, without waiting for an SCK edge.
REQ-022 A 3-bit bit counter SHALL increment on each sampled rising edge and wrap 7->0.
REQ-023 When RE=1, the byte SHALL move to RX_DATA one CLK after the 8th sampled bit, and RX_FULL SHALL set.
REQ-024 If RX_FULL is already set at that point, the new byte SHALL be discarded, RX_DATA held, and RX_OVERRUN set.
REQ-025 When RE=0, received bytes SHALL be discarded with no flag change.
REQ-026 WRITE while TX_FULL SHALL be ignored. WRITE in the same cycle as a LOAD consume SHALL be accepted, and TX_FULL SHALL stay 1.
REQ-027 READ SHALL clear RX_FULL. READ in the same cycle as a deposit SHALL let the deposit win: RX_FULL stays 1, no overrun.
REQ-028 CS deasserting with bit counter nonzero SHALL discard the partial byte, zero the counter, and set FRAME_ERR; the TX buffer is left untouched.
REQ-029 RX_OVERRUN, TX_UNDERRUN and FRAME_ERR SHALL be sticky until a cycle with CONTROL[3]=1. A set event in that same cycle wins.
REQ-030 STATUS[7] SHALL equal synchronized CS low.
REQ-031 MISO SHALL be 0 whenever MISO_OE=0.

Reset
REQ-032 CLR low SHALL asynchronously force: FSM to IDLE; counter, shift register, TX buffer, RX_DATA, STATUS, MISO and MISO_OE to 0; synchronizer flops to SCK=0, CS=1, MOSI=0.
REQ-033 Reset asserted mid-transfer SHALL abort the transfer with no flag set. After release, the block SHALL wait for a fresh CS falling edge.

Structure
REQ-034 Package spi_pkg SHALL hold the FSM state type and the STATUS/CONTROL bit-index constants, shared with the master-side control block.
REQ-035 Sub-module spi_sync SHALL be a parameterized SYNC_STAGES-deep synchronizer, instantiated once each for SCK, CS and MOSI.

Verification
REQ-036 TE=RE=1, WRITE 8'hA5, master sends 8'h3C -> MISO bits read 1,0,1,0,0,1,0,1; RX_DATA=8'h3C; STATUS[1]=1; STATUS[0]=0.
REQ-037 Two back-to-back bytes 8'h11, 8'h22 under one CS with no READ -> RX_DATA=8'h11; STATUS[2]=1.
REQ-038 No WRITE, one byte clocked -> MISO all 0; STATUS[3]=1; CONTROL[3] pulse -> STATUS[3]=0.
REQ-039 CS raised after 5 bits -> STATUS[4]=1; RX_FULL unchanged; next full byte received correctly.
REQ-040 CLR low after bit 3 -> all outputs 0 immediately; a new CS cycle with 8'h96 gives RX_DATA=8'h96.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state type and CONTROL/STATUS bit positions.
// Used by both the slave and master-side control blocks.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } spi_state_e;

  localparam int CTRL_TE      = 2;
  localparam int CTRL_CLR_ERR = 3;
  localparam int CTRL_RE      = 6;

  localparam int STAT_TX_FULL    = 0;
  localparam int STAT_RX_FULL    = 1;
  localparam int STAT_RX_OVERRUN = 2;
  localparam int STAT_TX_UNDER   = 3;
  localparam int STAT_FRAME_ERR  = 4;
  localparam int STAT_SELECTED   = 7;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input bit.
// Reset value is a parameter so idle levels survive reset.
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {STAGES{RST_VAL}};
    else        sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave_control.sv
// SPI mode-0 slave: synchronized SCK/CS/MOSI, one-byte TX and RX buffers,
// sticky error flags and an IDLE/LOAD/SHIFT control FSM.
module spi_slave_control #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       SCK,
  input  logic       CS,
  input  logic       MOSI,
  output logic       MISO,
  output logic       MISO_OE,
  input  logic [7:0] TX_DATA,
  input  logic       WRITE,
  input  logic       READ,
  output logic [7:0] RX_DATA,
  input  logic [7:0] CONTROL,
  output logic [7:0] STATUS
);
  import spi_pkg::*;

  logic sck_s, cs_s, mosi_s;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
    .clk(CLK), .rst_n(CLR), .d(SCK), .q(sck_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(CLK), .rst_n(CLR), .d(CS), .q(cs_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk(CLK), .rst_n(CLR), .d(MOSI), .q(mosi_s)
  );

  spi_state_e state_q, state_d;
  logic sck_prev_q, sck_prev_d;
  logic cs_prev_q, cs_prev_d;
  logic armed_q, armed_d;
  logic [SYNC_STAGES-1:0] flush_q, flush_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic [7:0] tx_buf_q, tx_buf_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic done_q, done_d;
  logic tx_full_q, tx_full_d;
  logic rx_full_q, rx_full_d;
  logic ovr_q, ovr_d;
  logic und_q, und_d;
  logic ferr_q, ferr_d;
  logic sel_q, sel_d;
  logic miso_q, miso_d;
  logic oe_q, oe_d;

  logic te, re, clr_err;
  logic sck_rise, sck_fall, cs_fall;
  logic consume;
  logic ovr_set, und_set, ferr_set;
  logic unused_ctrl;

  assign te      = CONTROL[CTRL_TE];
  assign re      = CONTROL[CTRL_RE];
  assign clr_err = CONTROL[CTRL_CLR_ERR];
  assign unused_ctrl = ^{CONTROL[7], CONTROL[5:4], CONTROL[1:0]};

  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  // A CS low seen straight out of reset is not a fresh edge.
  assign cs_fall  = cs_prev_q & ~cs_s & armed_q;
  assign consume  = (state_q == ST_LOAD) & ~cs_s & tx_full_q;

  always_comb begin
    state_d    = state_q;
    sck_prev_d = sck_s;
    cs_prev_d  = cs_s;
    flush_d    = {flush_q[SYNC_STAGES-2:0], 1'b1};
    armed_d    = armed_q | (flush_q[SYNC_STAGES-1] & cs_s);
    cnt_d      = cnt_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    tx_buf_d   = tx_buf_q;
    rx_data_d  = rx_data_q;
    done_d     = 1'b0;
    tx_full_d  = tx_full_q;
    rx_full_d  = rx_full_q;
    ovr_set    = 1'b0;
    und_set    = 1'b0;
    ferr_set   = 1'b0;

    if (cs_s) begin
      state_d = ST_IDLE;
      if (cnt_q != 3'd0) begin
        ferr_set = 1'b1;
        cnt_d    = 3'd0;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cs_fall) state_d = ST_LOAD;
        end
        ST_LOAD: begin
          state_d = ST_SHIFT;
          if (tx_full_q) begin
            tx_sh_d   = tx_buf_q;
            tx_full_d = 1'b0;
          end else begin
            tx_sh_d = 8'h00;
            und_set = te;
          end
        end
        ST_SHIFT: begin
          if (sck_rise) begin
            rx_sh_d = {rx_sh_q[6:0], mosi_s};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              state_d = ST_LOAD;
              done_d  = 1'b1;
            end
          end else if (sck_fall && cnt_q != 3'd0) begin
            // Fall after the last bit belongs to the next byte's MSB.
            tx_sh_d = {tx_sh_q[6:0], 1'b0};
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (WRITE && (!tx_full_q || consume)) begin
      tx_buf_d  = TX_DATA;
      tx_full_d = 1'b1;
    end

    if (READ) rx_full_d = 1'b0;

    if (done_q && re) begin
      if (rx_full_q && !READ) begin
        ovr_set = 1'b1;
      end else begin
        rx_data_d = rx_sh_q;
        rx_full_d = 1'b1;
      end
    end

    ovr_d  = (ovr_q & ~clr_err) | ovr_set;
    und_d  = (und_q & ~clr_err) | und_set;
    ferr_d = (ferr_q & ~clr_err) | ferr_set;
    sel_d  = ~cs_s;
    oe_d   = ~cs_s & te & (state_q != ST_IDLE);
    miso_d = oe_d & tx_sh_d[7];
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q    <= ST_IDLE;
      sck_prev_q <= 1'b0;
      cs_prev_q  <= 1'b1;
      armed_q    <= 1'b0;
      flush_q    <= '0;
      cnt_q      <= 3'd0;
      tx_sh_q    <= 8'h00;
      rx_sh_q    <= 8'h00;
      tx_buf_q   <= 8'h00;
      rx_data_q  <= 8'h00;
      done_q     <= 1'b0;
      tx_full_q  <= 1'b0;
      rx_full_q  <= 1'b0;
      ovr_q      <= 1'b0;
      und_q      <= 1'b0;
      ferr_q     <= 1'b0;
      sel_q      <= 1'b0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      sck_prev_q <= sck_prev_d;
      cs_prev_q  <= cs_prev_d;
      armed_q    <= armed_d;
      flush_q    <= flush_d;
      cnt_q      <= cnt_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      tx_buf_q   <= tx_buf_d;
      rx_data_q  <= rx_data_d;
      done_q     <= done_d;
      tx_full_q  <= tx_full_d;
      rx_full_q  <= rx_full_d;
      ovr_q      <= ovr_d;
      und_q      <= und_d;
      ferr_q     <= ferr_d;
      sel_q      <= sel_d;
      miso_q     <= miso_d;
      oe_q       <= oe_d;
    end
  end

  always_comb begin
    STATUS                  = 8'h00;
    STATUS[STAT_TX_FULL]    = tx_full_q;
    STATUS[STAT_RX_FULL]    = rx_full_q;
    STATUS[STAT_RX_OVERRUN] = ovr_q;
    STATUS[STAT_TX_UNDER]   = und_q;
    STATUS[STAT_FRAME_ERR]  = ferr_q;
    STATUS[STAT_SELECTED]   = sel_q;
  end

  assign RX_DATA = rx_data_q;
  assign MISO    = miso_q;
  assign MISO_OE = oe_q;

endmodule

// File: tb/tb_spi_slave_control.sv
// Directed plus randomized bench for spi_slave_control against a
// byte-level behavioural model of the slave's buffers and flags.
module tb_spi_slave_control;

  localparam int H = 8;

  logic       CLK = 1'b0;
  logic       CLR, SCK, CS, MOSI, WRITE, READ;
  logic       MISO, MISO_OE;
  logic [7:0] TX_DATA, RX_DATA, CONTROL, STATUS;

  int tests = 0;
  int fails = 0;

  bit         m_txf, m_rxf, m_ovr, m_und, m_ferr;
  logic [7:0] m_buf, m_rx;

  always #5 CLK = ~CLK;

  spi_slave_control #(.SYNC_STAGES(2)) dut (
    .CLK(CLK), .CLR(CLR), .SCK(SCK), .CS(CS), .MOSI(MOSI),
    .MISO(MISO), .MISO_OE(MISO_OE), .TX_DATA(TX_DATA),
    .WRITE(WRITE), .READ(READ), .RX_DATA(RX_DATA),
    .CONTROL(CONTROL), .STATUS(STATUS)
  );

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_status(input bit sel);
    return {sel, 2'b00, m_ferr, m_und, m_ovr, m_rxf, m_txf};
  endfunction

  task automatic m_reset();
    m_txf = 0; m_rxf = 0; m_ovr = 0; m_und = 0; m_ferr = 0;
    m_buf = 8'h00; m_rx = 8'h00;
  endtask

  // Slave begins a byte: takes the buffer or, if empty, zeros.
  task automatic m_load(output logic [7:0] exp_miso);
    logic [7:0] sent;
    sent = m_txf ? m_buf : 8'h00;
    if (!m_txf && CONTROL[2]) m_und = 1;
    m_txf = 0;
    exp_miso = CONTROL[2] ? sent : 8'h00;
  endtask

  task automatic m_recv(input logic [7:0] b);
    if (CONTROL[6]) begin
      if (m_rxf) m_ovr = 1;
      else begin
        m_rx  = b;
        m_rxf = 1;
      end
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wr(input logic [7:0] d);
    @(negedge CLK);
    TX_DATA = d;
    WRITE = 1;
    @(negedge CLK);
    WRITE = 0;
    if (!m_txf) begin
      m_buf = d;
      m_txf = 1;
    end
  endtask

  task automatic rd();
    @(negedge CLK);
    READ = 1;
    @(negedge CLK);
    READ = 0;
    m_rxf = 0;
  endtask

  task automatic clr_err();
    @(negedge CLK);
    CONTROL[3] = 1;
    @(negedge CLK);
    CONTROL[3] = 0;
    m_ovr = 0; m_und = 0; m_ferr = 0;
  endtask

  // Master side: MISO is sampled just before each rising SCK.
  task automatic shift_bits(input logic [7:0] d, input int n,
                            output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < n; i++) begin
      MOSI = d[7-i];
      clocks(H);
      got = {got[6:0], MISO};
      SCK = 1;
      clocks(H);
      SCK = 0;
    end
  endtask

  task automatic frame(input int n, input int part, input logic [7:0] d0,
                       input logic [7:0] d1, input logic [7:0] d2);
    logic [7:0] db[3];
    logic [7:0] exp, got;
    db[0] = d0; db[1] = d1; db[2] = d2;
    CS = 0;
    clocks(H);
    m_load(exp);
    chk("selected", {7'b0, STATUS[7]}, 8'h01);
    chk("miso_oe", {7'b0, MISO_OE}, {7'b0, CONTROL[2]});
    for (int b = 0; b < n; b++) begin
      shift_bits(db[b], 8, got);
      chk("miso_byte", got, exp);
      m_recv(db[b]);
      m_load(exp);
    end
    if (part > 0 && n < 3) begin
      shift_bits(db[n], part, got);
      chk("miso_part", got, exp >> (8 - part));
      m_ferr = 1;
    end
    clocks(H);
    CS = 1;
    clocks(H);
    chk("status", STATUS, m_status(1'b0));
    chk("rx_data", RX_DATA, m_rx);
  endtask

  initial begin
    logic [7:0] got;
    int n, part;
    CLR = 1; SCK = 0; CS = 1; MOSI = 0; WRITE = 0; READ = 0;
    TX_DATA = 8'h00; CONTROL = 8'h00;
    m_reset();
    #3 CLR = 0;
    clocks(3);
    chk("rst_status", STATUS, 8'h00);
    chk("rst_rx", RX_DATA, 8'h00);
    chk("rst_miso", {6'b0, MISO_OE, MISO}, 8'h00);
    CLR = 1;
    clocks(H);
    chk("idle_status", STATUS, 8'h00);

    CONTROL = 8'h44;
    wr(8'hA5);
    chk("tx_full", STATUS, m_status(1'b0));
    frame(1, 0, 8'h3C, 8'h00, 8'h00);
    chk("rx_3c", RX_DATA, 8'h3C);
    chk("rxf_txf", {6'b0, STATUS[1:0]}, 8'h02);
    rd();
    clr_err();
    chk("after_clr", STATUS, m_status(1'b0));

    frame(2, 0, 8'h11, 8'h22, 8'h00);
    chk("b2b_rx", RX_DATA, 8'h11);
    chk("b2b_ovr", {7'b0, STATUS[2]}, 8'h01);
    rd();
    clr_err();

    frame(1, 0, 8'h77, 8'h00, 8'h00);
    chk("und_set", {7'b0, STATUS[3]}, 8'h01);
    clr_err();
    chk("und_clr", {7'b0, STATUS[3]}, 8'h00);

    frame(0, 5, 8'hC3, 8'h00, 8'h00);
    chk("ferr", {7'b0, STATUS[4]}, 8'h01);
    chk("ferr_rxf", {7'b0, STATUS[1]}, 8'h01);
    rd();
    clr_err();
    frame(1, 0, 8'h5E, 8'h00, 8'h00);
    chk("post_ferr_rx", RX_DATA, 8'h5E);
    rd();

    wr(8'hF0);
    CS = 0;
    clocks(H);
    shift_bits(8'hB4, 3, got);
    clocks(2);
    CLR = 0;
    #1;
    chk("arst_status", STATUS, 8'h00);
    chk("arst_rx", RX_DATA, 8'h00);
    chk("arst_miso", {6'b0, MISO_OE, MISO}, 8'h00);
    m_reset();
    clocks(3);
    CLR = 1;
    clocks(H);
    shift_bits(8'hFF, 8, got);
    chk("stale_cs_miso", got, 8'h00);
    chk("stale_cs_stat", STATUS, m_status(1'b1));
    CS = 1;
    clocks(H);
    frame(1, 0, 8'h96, 8'h00, 8'h00);
    chk("rx_96", RX_DATA, 8'h96);

    for (int it = 0; it < 24; it++) begin
      CONTROL = 8'h00;
      CONTROL[2] = 1'($urandom_range(0, 3) != 0);
      CONTROL[6] = 1'($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) wr(8'($urandom));
      if ($urandom_range(0, 1) == 1) wr(8'($urandom));
      if ($urandom_range(0, 2) == 0) rd();
      if ($urandom_range(0, 3) == 0) clr_err();
      part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      n = (part > 0) ? $urandom_range(0, 2) : $urandom_range(1, 3);
      frame(n, part, 8'($urandom), 8'($urandom), 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
